// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller.
// Storage lives outside; this block issues accepted wr/rd strobes and addresses.
module fifo_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              flush,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_adr,
  output logic [ADDR_W-1:0] rd_adr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C =
    {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_P =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_wr_adr;
  logic [ADDR_W-1:0] r_rd_adr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [ADDR_W:0]   w_cnt_nxt;

  // Accept decode: a full FIFO still takes a write when a read frees a slot.
  always_comb begin
    w_rd_en = rd_req & ~r_empty & ~flush & ~reset;
    w_wr_en = wr_req & ~flush & ~reset
            & (~r_full | w_rd_en);
  end

  // Occupancy after this edge; flags are decoded from it.
  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_wr_en, w_rd_en})
      2'b10:   w_cnt_nxt = r_count + ONE_C;
      2'b01:   w_cnt_nxt = r_count - ONE_C;
      default: w_cnt_nxt = r_count;
    endcase
  end

  // State update: reset beats flush beats requests; flush keeps error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_adr <= '0;
      r_rd_adr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush) begin
      r_wr_adr <= '0;
      r_rd_adr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en) r_wr_adr <= r_wr_adr + ONE_P;
      if (w_rd_en) r_rd_adr <= r_rd_adr + ONE_P;
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == DEPTH);
      r_empty <= (w_cnt_nxt == '0);
      if (wr_req && !w_wr_en) r_ovf <= 1'b1;
      if (rd_req && !w_rd_en) r_udf <= 1'b1;
    end
  end

  assign wr_en  = w_wr_en;
  assign rd_en  = w_rd_en;
  assign wr_adr = r_wr_adr;
  assign rd_adr = r_rd_adr;
  assign count  = r_count;
  assign full   = r_full;
  assign empty  = r_empty;
  assign ovf    = r_ovf;
  assign udf    = r_udf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios then random traffic,
// compared each cycle against an occupancy/event-count model.
module tb_fifo_ctrl;

  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_adr;
  logic [AW-1:0] rd_adr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          udf;

  int total = 0;
  int bad = 0;

  int m_cnt = 0;
  int m_wr = 0;
  int m_rd = 0;
  bit m_ovf = 0;
  bit m_udf = 0;

  fifo_ctrl #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_req (wr_req),
    .rd_req (rd_req),
    .flush  (flush),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_adr (wr_adr),
    .rd_adr (rd_adr),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .udf    (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step(
    input bit w,
    input bit r,
    input bit f,
    input bit rst
  );
    bit ew;
    bit er;
    @(negedge clk);
    wr_req = w;
    rd_req = r;
    flush  = f;
    reset  = rst;
    #1;
    er = r && m_cnt > 0 && !f && !rst;
    ew = w && !f && !rst &&
         (m_cnt < DEPTH || er);
    chk("rd_en", int'(rd_en), int'(er));
    chk("wr_en", int'(wr_en), int'(ew));
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_wr = 0; m_rd = 0;
      m_ovf = 0; m_udf = 0;
    end else if (f) begin
      m_cnt = 0; m_wr = 0; m_rd = 0;
    end else begin
      if (w && !ew) m_ovf = 1;
      if (r && !er) m_udf = 1;
      if (ew) begin m_wr++; m_cnt++; end
      if (er) begin m_rd++; m_cnt--; end
    end
    #1;
    chk("count", int'(count), m_cnt);
    chk("wr_adr", int'(wr_adr), m_wr % DEPTH);
    chk("rd_adr", int'(rd_adr), m_rd % DEPTH);
    chk("full", int'(full), int'(m_cnt == DEPTH));
    chk("empty", int'(empty), int'(m_cnt == 0));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("udf", int'(udf), int'(m_udf));
  endtask

  initial begin
    step(0, 0, 0, 1);
    // fill to full, pointer wraps to 0
    for (int i = 0; i < DEPTH; i++)
      step(1, 0, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_wadr", int'(wr_adr), 0);
    // write into full: rejected, ovf
    step(1, 0, 0, 0);
    chk("ovf_set", int'(ovf), 1);
    // full with simultaneous push/pop
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 0);
    chk("pp_cnt", int'(count), DEPTH);
    chk("pp_radr", int'(rd_adr), 3);
    // drain, then push+pop on empty
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("e_cnt", int'(count), 1);
    chk("e_udf", int'(udf), 1);
    // count=5, flush with write
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("fl_cnt", int'(count), 0);
    // count=3 with ovf=1, then reset
    for (int i = 0; i < DEPTH + 1; i++)
      step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0);
    chk("pre_cnt", int'(count), 3);
    step(1, 1, 0, 1);
    chk("rst_ovf", int'(ovf), 0);
    step(0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 80) == 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 60) == 0,
           1'b0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 3, address width; FIFO depth is 2^ADDR_W entries (8 at default).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: wr_req  input  1  requester asks to push one entry this cycle.
REQ-005 Port: rd_req  input  1  requester asks to pop one entry this cycle.
REQ-006 Port: flush  input  1  synchronous discard of all stored entries.
REQ-007 Port: wr_en  output  1  write accepted this cycle; storage writes at wr_adr.
REQ-008 Port: rd_en  output  1  read accepted this cycle; storage reads at rd_adr.
REQ-009 Port: wr_adr  output  ADDR_W  current write pointer.
REQ-010 Port: rd_adr  output  ADDR_W  current read pointer.
REQ-011 Port: count  output  ADDR_W+1  number of occupied entries, 0..2^ADDR_W.
REQ-012 Port: full  output  1  count equals 2^ADDR_W.
REQ-013 Port: empty  output  1  count equals 0.
REQ-014 Port: ovf  output  1  sticky overflow error.
REQ-015 Port: udf  output  1  sticky underflow error.

Function
REQ-016 wr_en, rd_en: combinational, same-cycle decode of the current inputs and the registered state; no added latency.
REQ-017 rd_en: 1 iff rd_req=1, empty=0, flush=0, reset=0.
REQ-018 wr_en: 1 iff wr_req=1, flush=0, reset=0, and (full=0 or rd_en=1); a write to a full FIFO with a simultaneous accepted read succeeds.
REQ-019 Write while empty with rd_req=1: write accepted, read rejected; no fall-through.
REQ-020 wr_adr: increments by 1 modulo 2^ADDR_W on each clock edge with wr_en=1; wraps from 2^ADDR_W-1 to 0.
REQ-021 rd_adr: increments by 1 modulo 2^ADDR_W on each clock edge with rd_en=1, with the same wrap rule.
REQ-022 count next value: +1 if only wr_en, -1 if only rd_en, unchanged if both or neither.
REQ-023 count: never exceeds 2^ADDR_W and never goes below 0.
REQ-024 full and empty: registered, decoded from the next count, valid in the same cycle as count.
REQ-025 flush=1 at a clock edge: wr_adr, rd_adr and count go to 0, empty goes to 1, full goes to 0; flush takes priority over all requests.
REQ-026 flush leaves ovf and udf unchanged.
REQ-027 ovf: set on any edge where wr_req=1, wr_en=0, flush=0, reset=0; stays set until reset.
REQ-028 udf: set on any edge where rd_req=1, rd_en=0, flush=0, reset=0; stays set until reset.
REQ-029 Rejected requests: no change to pointers or count.

Reset
REQ-030 reset=1 at a clock edge: wr_adr=0, rd_adr=0, count=0, empty=1, full=0, ovf=0, udf=0.
REQ-031 While reset=1: wr_en=0 and rd_en=0 regardless of requests.
REQ-032 reset has priority over flush and all requests.
REQ-033 Reset asserted mid-operation: all stored entries are discarded.

Verification
REQ-034 Reset, then 8 consecutive wr_req cycles -> wr_adr steps 1..7 then wraps to 0; count=8, full=1, ovf=0.
REQ-035 Full FIFO, one more wr_req alone -> wr_en=0, count stays 8, ovf=1 from the next cycle.
REQ-036 Full FIFO, wr_req=rd_req=1 for 3 cycles -> wr_en=rd_en=1 each cycle; count stays 8; wr_adr and rd_adr both advance by 3.
REQ-037 Empty FIFO, wr_req=rd_req=1 -> wr_en=1, rd_en=0, udf=1; count=1 and empty=0 after the edge.
REQ-038 count=5, assert flush together with wr_req -> next cycle count=0, empty=1, both pointers 0, ovf and udf unchanged.
REQ-039 count=3, assert reset for 1 cycle with ovf=1 -> all outputs at reset values, including ovf=0; wr_en=0 during reset.
